// File: rtl/muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit.
//  - md_op_e     : operation encodings carried on the op port
//  - md_state_e  : FSM states (IDLE, RUN, DONE)
//  - md_is_signed / md_is_mul : decode helpers for the op field
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } md_state_e;

    // Even encodings (MULT, DIV) are the signed variants.
    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Upper bit clear selects multiply.
    function automatic logic md_is_mul(input logic [1:0] op);
        return ~op[1];
    endfunction

endpackage

// File: rtl/seq_muldiv_if.sv
// Request/result bundle between the integer pipeline and seq_muldiv.
//  master (pipeline): drives op1, op2, op, go; sees hi, lo, hold, busy
//  slave  (unit)    : the reverse
interface seq_muldiv_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [1:0]       op;
    logic             go;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             hold;
    logic             busy;

    modport master (output op1, op2, op, go, input hi, lo, hold, busy);
    modport slave  (input op1, op2, op, go, output hi, lo, hold, busy);
endinterface

// File: rtl/muldiv_step.sv
// One radix-2^BITS iteration of the multiply/divide datapath (combinational).
//  mul_mode : 1 = shift-add multiply step, 0 = restoring divide step
//  acc_in   : multiply: 2W-bit partial product; divide: {rem, quo}
//  mcand    : multiplicand already shifted to the current bit position
//  mbits    : next BITS multiplier bits (LSB first)
//  divisor  : divisor magnitude
//  acc_out  : accumulator after BITS stages
module muldiv_step #(
    parameter int WIDTH = 32,
    parameter int BITS  = 1
) (
    input  logic                 mul_mode,
    input  logic [2*WIDTH-1:0]   acc_in,
    input  logic [2*WIDTH-1:0]   mcand,
    input  logic [BITS-1:0]      mbits,
    input  logic [WIDTH-1:0]     divisor,
    output logic [2*WIDTH-1:0]   acc_out
);

    logic [2*WIDTH-1:0] mul_acc;
    logic [2*WIDTH-1:0] div_acc;
    logic [WIDTH:0]     trial;

    always_comb begin
        mul_acc = acc_in;
        div_acc = acc_in;
        trial   = '0;
        for (int i = 0; i < BITS; i++) begin
            if (mbits[i]) begin
                mul_acc = mul_acc + (mcand << i);
            end
            // Trial subtract on the remainder with the next dividend bit
            // shifted in; W+1 bits so the borrow shows up in the MSB.
            trial = div_acc[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
            if (trial[WIDTH]) begin
                div_acc = {div_acc[2*WIDTH-2:0], 1'b0};
            end else begin
                div_acc = {trial[WIDTH-1:0], div_acc[WIDTH-2:0], 1'b1};
            end
        end
        acc_out = mul_mode ? mul_acc : div_acc;
    end

endmodule

// File: rtl/seq_muldiv.sv
// Iterative signed/unsigned multiply and divide unit producing HI/LO.
//  clk, rst : clock, synchronous active-high reset
//  bus      : seq_muldiv_if slave (op1, op2, op, go in; hi, lo, hold, busy out)
// Operands are reduced to magnitudes at start; the sign fixup is applied
// when the result is written into hi/lo on entry to DONE.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int BITS_PER_CYCLE = 1,
    parameter int EARLY_OUT      = 1
) (
    input  logic         clk,
    input  logic         rst,
    seq_muldiv_if.slave  bus
);

    localparam int STEPS = WIDTH / BITS_PER_CYCLE;
    localparam int CW    = $clog2(STEPS + 1);

    md_state_e            state_reg, state_next;
    logic                 mul_reg, qsign_reg, rsign_reg, divzero_reg, busy_reg;
    logic [2*WIDTH-1:0]   acc_reg, mcand_reg;
    logic [WIDTH-1:0]     mplier_reg, hi_reg, lo_reg;
    logic [CW-1:0]        count_reg;

    logic                 op_mul, op_signed, neg1, neg2, start_zero, run_last;
    logic [WIDTH-1:0]     mag1, mag2, mplier_shift, quo_fix, rem_fix, res_hi, res_lo;
    logic [2*WIDTH-1:0]   step_acc, prod_fix;

    muldiv_step #(.WIDTH(WIDTH), .BITS(BITS_PER_CYCLE)) u_step (
        .mul_mode (mul_reg),
        .acc_in   (acc_reg),
        .mcand    (mcand_reg),
        .mbits    (mplier_reg[BITS_PER_CYCLE-1:0]),
        .divisor  (mcand_reg[WIDTH-1:0]),
        .acc_out  (step_acc)
    );

    always_comb begin
        op_mul       = md_is_mul(bus.op);
        op_signed    = md_is_signed(bus.op);
        neg1         = op_signed & bus.op1[WIDTH-1];
        neg2         = op_signed & bus.op2[WIDTH-1];
        // -2^(W-1) negates to itself, which is its correct unsigned magnitude.
        mag1         = neg1 ? -bus.op1 : bus.op1;
        mag2         = neg2 ? -bus.op2 : bus.op2;
        start_zero   = op_mul && (EARLY_OUT != 0) && (mag1 == '0);
        mplier_shift = mplier_reg >> BITS_PER_CYCLE;
        run_last     = (count_reg == CW'(STEPS - 1)) ||
                       (mul_reg && (EARLY_OUT != 0) && (mplier_shift == '0));
        prod_fix     = qsign_reg ? -step_acc : step_acc;
        quo_fix      = divzero_reg ? '1 :
                       (qsign_reg ? -step_acc[WIDTH-1:0] : step_acc[WIDTH-1:0]);
        // With a zero divisor the remainder ends up as |op1|, so this
        // restores the raw dividend.
        rem_fix      = rsign_reg ? -step_acc[2*WIDTH-1:WIDTH] : step_acc[2*WIDTH-1:WIDTH];
        res_hi       = mul_reg ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
        res_lo       = mul_reg ? prod_fix[WIDTH-1:0]       : quo_fix;
    end

    always_comb begin
        state_next = state_reg;
        bus.hold   = bus.go & (state_reg != ST_DONE);
        case (state_reg)
            ST_IDLE: if (bus.go) state_next = start_zero ? ST_DONE : ST_RUN;
            ST_RUN:  if (run_last) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            busy_reg    <= 1'b0;
            hi_reg      <= '0;
            lo_reg      <= '0;
            mul_reg     <= 1'b0;
            qsign_reg   <= 1'b0;
            rsign_reg   <= 1'b0;
            divzero_reg <= 1'b0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            count_reg   <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next != ST_IDLE);
            case (state_reg)
                ST_IDLE: if (bus.go) begin
                    mul_reg     <= op_mul;
                    qsign_reg   <= neg1 ^ neg2;
                    rsign_reg   <= neg1;
                    divzero_reg <= ~op_mul & (bus.op2 == '0);
                    // Divide keeps {rem, quo} in the accumulator, dividend in quo.
                    acc_reg     <= op_mul ? '0 : {{WIDTH{1'b0}}, mag1};
                    mcand_reg   <= {{WIDTH{1'b0}}, mag2};
                    mplier_reg  <= mag1;
                    count_reg   <= '0;
                    if (start_zero) begin
                        hi_reg <= '0;
                        lo_reg <= '0;
                    end
                end
                ST_RUN: begin
                    acc_reg    <= step_acc;
                    mplier_reg <= mplier_shift;
                    count_reg  <= count_reg + 1'b1;
                    if (mul_reg) mcand_reg <= mcand_reg << BITS_PER_CYCLE;
                    if (run_last) begin
                        hi_reg <= res_hi;
                        lo_reg <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi   = hi_reg;
    assign bus.lo   = lo_reg;
    assign bus.busy = busy_reg;

endmodule

// File: tb/tb_seq_muldiv.sv
// Self-checking bench for seq_muldiv: three instances (1, 2 and 4 bits per
// cycle, early-out enabled) share operand wires with per-instance go lines.
module tb_seq_muldiv;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] op1_v, op2_v;
    logic [1:0]   op_v;
    logic         go_v [3];
    logic         hold_w [3];
    logic         busy_w [3];
    logic [W-1:0] hi_w [3];
    logic [W-1:0] lo_w [3];
    logic         gap_prev [3];

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_muldiv_if #(.WIDTH(W)) if0 ();
    seq_muldiv_if #(.WIDTH(W)) if1 ();
    seq_muldiv_if #(.WIDTH(W)) if2 ();

    assign if0.op1 = op1_v;  assign if0.op2 = op2_v;  assign if0.op = op_v;  assign if0.go = go_v[0];
    assign if1.op1 = op1_v;  assign if1.op2 = op2_v;  assign if1.op = op_v;  assign if1.go = go_v[1];
    assign if2.op1 = op1_v;  assign if2.op2 = op2_v;  assign if2.op = op_v;  assign if2.go = go_v[2];

    assign hold_w[0] = if0.hold;  assign busy_w[0] = if0.busy;  assign hi_w[0] = if0.hi;  assign lo_w[0] = if0.lo;
    assign hold_w[1] = if1.hold;  assign busy_w[1] = if1.busy;  assign hi_w[1] = if1.hi;  assign lo_w[1] = if1.lo;
    assign hold_w[2] = if2.hold;  assign busy_w[2] = if2.busy;  assign hi_w[2] = if2.hi;  assign lo_w[2] = if2.lo;

    seq_muldiv #(.WIDTH(W), .BITS_PER_CYCLE(1), .EARLY_OUT(1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    seq_muldiv #(.WIDTH(W), .BITS_PER_CYCLE(2), .EARLY_OUT(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    seq_muldiv #(.WIDTH(W), .BITS_PER_CYCLE(4), .EARLY_OUT(1)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    // Behavioural model: plain 64-bit arithmetic plus the latency formulas.
    task automatic ref_model(input logic [1:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                             input int r, output logic [W-1:0] eh, output logic [W-1:0] el,
                             output int lat);
        longint       sa, sb;
        logic [63:0]  t, q, m;
        logic [W-1:0] mag;
        int           n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = '0;
        el = '0;
        if (opc == MD_MULT) begin
            t = sa * sb;
            {eh, el} = t;
        end else if (opc == MD_MULTU) begin
            t = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            {eh, el} = t;
        end else if (b == '0) begin
            el = '1;
            eh = a;
        end else if (opc == MD_DIV) begin
            q = sa / sb;
            m = sa % sb;
            el = q[W-1:0];
            eh = m[W-1:0];
        end else begin
            el = a / b;
            eh = a % b;
        end
        if (opc[1]) begin
            lat = 1 + W / r;
        end else begin
            mag = (opc == MD_MULT && a[W-1]) ? -a : a;
            n = 0;
            while (mag != '0) begin
                n++;
                mag = mag >> 1;
            end
            lat = (n == 0) ? 1 : 1 + (n + r - 1) / r;
        end
    endtask

    // Issue one op on instance sel, count hold-high cycles, compare with model.
    task automatic run_op(input int sel, input logic [1:0] opc, input logic [W-1:0] a,
                          input logic [W-1:0] b, input bit keep_go,
                          output logic [W-1:0] got_hi, output logic [W-1:0] got_lo,
                          output int got_lat);
        logic [W-1:0] eh, el;
        int lat, cyc, r;
        r = (sel == 0) ? 1 : (sel == 1) ? 2 : 4;
        ref_model(opc, a, b, r, eh, el, lat);
        @(negedge clk);
        op_v = opc; op1_v = a; op2_v = b; go_v[sel] = 1'b1;
        #1;
        cyc = 0;
        while (hold_w[sel] && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        got_hi = hi_w[sel]; got_lo = lo_w[sel]; got_lat = cyc;
        $display("R=%0d op=%0d a=%h b=%h -> hi=%h lo=%h hold=%0d (model %h %h %0d)",
                 r, opc, a, b, got_hi, got_lo, cyc, eh, el, lat);
        check($sformatf("lat_r%0d_op%0d", r, opc), 64'(cyc), 64'(lat));
        check($sformatf("hi_r%0d_op%0d", r, opc), 64'(got_hi), 64'(eh));
        check($sformatf("lo_r%0d_op%0d", r, opc), 64'(got_lo), 64'(el));
        if (!keep_go) go_v[sel] = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_opnd();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = 32'd1;
            2:       v = '1;
            3:       v = 32'h8000_0000;
            4:       v = W'($urandom_range(0, 255));
            5:       v = -W'($urandom_range(1, 255));
            default: v = $urandom();
        endcase
        return v;
    endfunction

    // A cycle with go high and hold low must be followed by hold high while go stays high.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst && go_v[i] && gap_prev[i]) check("hold_gap", 64'(hold_w[i]), 64'd1);
            gap_prev[i] <= go_v[i] && !hold_w[i];
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] h, l;
        int lat, cyc, nops;
        bit keep;
        logic hold_any;

        rst = 1'b1;
        op_v = MD_MULT; op1_v = '0; op2_v = '0;
        for (int i = 0; i < 3; i++) begin
            go_v[i] = 1'b0;
            gap_prev[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        check("rst_hi", 64'(hi_w[0]), 64'd0);
        check("rst_lo", 64'(lo_w[0]), 64'd0);
        check("rst_busy", 64'(busy_w[0]), 64'd0);
        check("rst_hold", 64'(hold_w[0]), 64'd0);
        go_v[0] = 1'b1;
        #1;
        check("rst_hold_go", 64'(hold_w[0]), 64'd1);
        go_v[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // 1: MULTU 7*6, four hold cycles
        run_op(0, MD_MULTU, 32'd7, 32'd6, 1'b0, h, l, lat);
        check("t1_lo", 64'(l), 64'd42);
        check("t1_lat", 64'(lat), 64'd4);

        // 2: back-to-back MULT then DIV with go held
        run_op(0, MD_MULT, -32'sd3, 32'd5, 1'b1, h, l, lat);
        check("t2_mul_lo", 64'(l), 64'h0000_0000_FFFF_FFF1);
        check("t2_mul_hi", 64'(h), 64'h0000_0000_FFFF_FFFF);
        run_op(0, MD_DIV, -32'sd7, 32'd2, 1'b0, h, l, lat);
        check("t2_div_lo", 64'(l), 64'h0000_0000_FFFF_FFFD);
        check("t2_div_hi", 64'(h), 64'h0000_0000_FFFF_FFFF);

        // 3: divide by zero and signed overflow
        run_op(0, MD_DIVU, 32'hFFFF_FFFF, 32'd0, 1'b0, h, l, lat);
        check("t3_dz_lo", 64'(l), 64'h0000_0000_FFFF_FFFF);
        check("t3_dz_hi", 64'(h), 64'h0000_0000_FFFF_FFFF);
        check("t3_dz_lat", 64'(lat), 64'd33);
        run_op(0, MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, h, l, lat);
        check("t3_ov_lo", 64'(l), 64'h0000_0000_8000_0000);
        check("t3_ov_hi", 64'(h), 64'd0);

        // 4: full-width MULTU at each radix
        for (int s = 0; s < 3; s++) begin
            run_op(s, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, h, l, lat);
            check("t4_hi", 64'(h), 64'h0000_0000_FFFF_FFFE);
            check("t4_lo", 64'(l), 64'd1);
            check("t4_lat", 64'(lat), (s == 0) ? 64'd33 : (s == 1) ? 64'd17 : 64'd9);
        end

        // 5: reset in the 5th cycle of DIVU 100/7, go kept high
        @(negedge clk);
        op_v = MD_DIVU; op1_v = 32'd100; op2_v = 32'd7; go_v[0] = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_hi", 64'(hi_w[0]), 64'd0);
        check("t5_rst_lo", 64'(lo_w[0]), 64'd0);
        check("t5_rst_busy", 64'(busy_w[0]), 64'd0);
        cyc = 0;
        while (hold_w[0] && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        $display("R=1 restart DIVU 100/7 -> hi=%h lo=%h hold=%0d", hi_w[0], lo_w[0], cyc);
        check("t5_lat", 64'(cyc), 64'd33);
        check("t5_lo", 64'(lo_w[0]), 64'd14);
        check("t5_hi", 64'(hi_w[0]), 64'd2);
        go_v[0] = 1'b0;

        // 6: go dropped after the start cycle
        @(negedge clk);
        op_v = MD_MULT; op1_v = 32'd3; op2_v = 32'd3; go_v[0] = 1'b1;
        @(negedge clk);
        go_v[0] = 1'b0;
        hold_any = 1'b0;
        cyc = 0;
        #1;
        while (busy_w[0] && cyc < 100) begin
            hold_any |= hold_w[0];
            cyc++;
            @(negedge clk);
            #1;
        end
        $display("R=1 MULT 3*3 go dropped -> hi=%h lo=%h busy cycles=%0d", hi_w[0], lo_w[0], cyc);
        check("t6_busy_end", 64'(busy_w[0]), 64'd0);
        check("t6_hold", 64'(hold_any), 64'd0);
        check("t6_hi", 64'(hi_w[0]), 64'd0);
        check("t6_lo", 64'(lo_w[0]), 64'd9);

        // Randomised ops on each instance, random back-to-back chaining
        nops = 150;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < nops; k++) begin
                keep = (k != nops - 1) && ($urandom_range(0, 1) == 1);
                run_op(s, 2'($urandom_range(0, 3)), rand_opnd(), rand_opnd(), keep, h, l, lat);
            end
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
